instruction_cache: RTL

Direct-mapped, read-only instruction cache between the PC/fetch logic and instruction memory. It supplies `instruction` and `busywait` to the IF/ID pipeline register, and refills whole blocks from memory over a read/busywait handshake on a miss. While `busywait` is high, the IF/ID register holds its contents; when it is low, `instruction` is the valid word at `address`.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/instruction_cache_if.sv | 47 ++++
 rtl/icache_data_array.sv | 53 +++++
 rtl/instruction_cache.sv | 108 ++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Block = 4 words = 128 bits; memory is addressed in whole blocks.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_e;

    localparam int ADDR_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int MEM_ADDR_W      = 28;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFF_W           = 2;

    function automatic int idx_w(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int tag_w(input int num_blocks);
        return MEM_ADDR_W - idx_w(num_blocks);
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side bundles of the instruction cache.
// master drives the request, slave answers it.
interface icache_fetch_if;
    import icache_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic [31:0]       instruction;
    logic              busywait;

    modport master (
        output address,
        output read,
        input  instruction,
        input  busywait
    );

    modport slave (
        input  address,
        input  read,
        output instruction,
        output busywait
    );
endinterface

interface icache_mem_if;
    import icache_pkg::*;

    logic                  mem_read;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    modport master (
        output mem_read,
        output mem_address,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/icache_data_array.sv
// Valid/tag/data storage: one write port, combinational read by index.
// Only the valid bits are reset; tag and data are qualified by them.
module icache_data_array
    import icache_pkg::*;
#(
    parameter  int NUM_BLOCKS = 8,
    localparam int IDX_W      = idx_w(NUM_BLOCKS),
    localparam int TAG_W      = tag_w(NUM_BLOCKS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   widx,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic [IDX_W-1:0]   ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output logic [BLOCK_W-1:0] rdata
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[widx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with whole-block refill.
// Hits are zero-latency; a miss runs IDLE -> MEM_READ -> UPDATE -> IDLE.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    icache_fetch_if.slave    fetch,
    icache_mem_if.master     mem
);

    localparam int IDX_W = idx_w(NUM_BLOCKS);
    localparam int TAG_W = tag_w(NUM_BLOCKS);

    state_e                state_q;
    state_e                state_d;
    logic [MEM_ADDR_W-1:0] miss_addr_q;
    logic [MEM_ADDR_W-1:0] miss_addr_d;

    logic [OFF_W-1:0]   offset;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               blk_valid;
    logic [TAG_W-1:0]   blk_tag;
    logic [BLOCK_W-1:0] blk_data;
    logic               hit;
    logic               fill_we;
    logic [31:0]        instr;
    logic               unused_addr_lsb;

    assign offset          = fetch.address[3:2];
    assign idx             = fetch.address[4 +: IDX_W];
    assign tag             = fetch.address[ADDR_W-1 -: TAG_W];
    assign unused_addr_lsb = ^fetch.address[1:0];

    // Refill lands in the block named by the latched miss, not the live PC.
    assign fill_we = (state_q == MEM_READ) && !mem.mem_busywait;

    icache_data_array #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (fill_we),
        .widx   (miss_addr_q[IDX_W-1:0]),
        .wtag   (miss_addr_q[MEM_ADDR_W-1:IDX_W]),
        .wdata  (mem.mem_readdata),
        .ridx   (idx),
        .rvalid (blk_valid),
        .rtag   (blk_tag),
        .rdata  (blk_data)
    );

    assign hit = blk_valid && (blk_tag == tag);

    always_comb begin
        instr = blk_data[31:0];
        unique case (offset)
            2'd0: instr = blk_data[31:0];
            2'd1: instr = blk_data[63:32];
            2'd2: instr = blk_data[95:64];
            2'd3: instr = blk_data[127:96];
            default: instr = blk_data[31:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        unique case (state_q)
            IDLE: begin
                if (fetch.read && !hit) begin
                    miss_addr_d = fetch.address[ADDR_W-1:4];
                    state_d     = MEM_READ;
                end
            end
            MEM_READ: begin
                if (!mem.mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    assign fetch.instruction = instr;
    assign fetch.busywait    = (state_q != IDLE) || (fetch.read && !hit);
    assign mem.mem_read      = (state_q == MEM_READ);
    assign mem.mem_address   = miss_addr_q;

endmodule
